// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
// Collects results from FU_NUM functional units into small per-port FIFOs and
// broadcasts up to CDB_SIZE of them per cycle on the common data bus. Ports
// are served round-robin so that no port starves.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous pipeline flush; empties everything
//   fu_valid[i]       port i offers a result this cycle
//   fu_reorder[i]     ROB tag of that result
//   fu_value[i]       32-bit result data
//   fu_ready[i]       port i accepts a result this cycle
//   cdb[l]            registered lane l, packed as {valid, reorder, value}
`ifndef CDB_SIZE
`define CDB_SIZE 2
`endif

module cdb_broadcaster #(
  parameter int FU_NUM     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CDB_SIZE   = `CDB_SIZE,
  parameter int ROB_BITS   = 5,
  localparam int LANE_BITS = 1 + ROB_BITS + 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [FU_NUM-1:0]                    fu_valid,
  input  logic [FU_NUM-1:0][ROB_BITS-1:0]      fu_reorder,
  input  logic [FU_NUM-1:0][31:0]              fu_value,
  output logic [FU_NUM-1:0]                    fu_ready,
  output logic [CDB_SIZE-1:0][LANE_BITS-1:0]   cdb
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RR_W   = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int LANE_W = (CDB_SIZE > 1) ? $clog2(CDB_SIZE) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [RR_W:0]     FU_C      = (RR_W+1)'(FU_NUM);
  localparam logic [RR_W-1:0]   LAST_PORT = RR_W'(FU_NUM - 1);
  localparam logic [LANE_W:0]   GNT_MAX   = (LANE_W+1)'(CDB_SIZE);

  typedef struct packed {
    logic [ROB_BITS-1:0] reorder;
    logic [31:0]         value;
  } entry_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_BITS-1:0] reorder;
    logic [31:0]         value;
  } lane_t;

  entry_t mem_q [FU_NUM][FIFO_DEPTH];
  entry_t mem_d [FU_NUM][FIFO_DEPTH];

  logic [FU_NUM-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FU_NUM-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FU_NUM-1:0][CNT_W-1:0] count_q, count_d;
  logic [RR_W-1:0]              rr_ptr_q, rr_ptr_d;
  lane_t [CDB_SIZE-1:0]         cdb_q, cdb_d;

  logic [FU_NUM-1:0] push;
  logic [FU_NUM-1:0] pop;
  logic [RR_W:0]     scan_sum;
  logic [RR_W-1:0]   scan_idx;
  logic [RR_W-1:0]   last_gnt;
  logic [LANE_W:0]   n_gnt;

  assign cdb = cdb_q;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      fu_ready[i] = (count_q[i] < DEPTH_C) && !flush;
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  // Round-robin scan starting at rr_ptr; only entries already in a FIFO
  // (registered count) can win, so a fresh push waits one cycle.
  always_comb begin
    pop      = '0;
    cdb_d    = '0;
    n_gnt    = '0;
    last_gnt = rr_ptr_q;
    scan_sum = '0;
    scan_idx = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < FU_NUM; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
      if (scan_sum >= FU_C) begin
        scan_sum = scan_sum - FU_C;
      end
      scan_idx = scan_sum[RR_W-1:0];
      if ((count_q[scan_idx] != '0) && (n_gnt < GNT_MAX)) begin
        pop[scan_idx]               = 1'b1;
        cdb_d[n_gnt[LANE_W-1:0]]    = {1'b1, mem_q[scan_idx][rd_ptr_q[scan_idx]]};
        n_gnt                       = n_gnt + 1'b1;
        last_gnt                    = scan_idx;
      end
    end
    if (n_gnt != '0) begin
      rr_ptr_d = (last_gnt == LAST_PORT) ? '0 : last_gnt + 1'b1;
    end
    // Flush overrides every grant and restarts the rotation at port 0.
    if (flush) begin
      pop      = '0;
      cdb_d    = '0;
      rr_ptr_d = '0;
    end
  end

  // FIFO bookkeeping; pointers wrap for free because the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < FU_NUM; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = {fu_reorder[i], fu_value[i]};
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster
// Self-checking bench for cdb_broadcaster (FU_NUM=4, FIFO_DEPTH=2, CDB_SIZE=2).
// A queue-based reference model tracks per-port result queues and the
// round-robin start port; a compare process checks every lane and fu_ready
// on each falling edge. Directed sequences pin the model with literal values,
// then a long randomized run exercises backpressure, flush and async reset.
module tb_cdb_broadcaster;

  localparam int FU    = 4;
  localparam int DEPTH = 2;
  localparam int CDB   = 2;
  localparam int RB    = 5;
  localparam int LB    = 1 + RB + 32;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic [FU-1:0]          fu_valid   = '0;
  logic [FU-1:0][RB-1:0]  fu_reorder = '0;
  logic [FU-1:0][31:0]    fu_value   = '0;
  logic [FU-1:0]          fu_ready;
  logic [CDB-1:0][LB-1:0] cdb;

  int n_compared = 0;
  int n_failed   = 0;
  bit chk_en     = 1'b0;

  // Reference model state
  logic [RB+31:0] mq [FU][$];
  logic [LB-1:0]  exp_lane [CDB];
  int             rr = 0;
  logic [FU-1:0]  m_acc;
  int             m_n, m_last, m_p;
  logic [RB+31:0] m_head;

  cdb_broadcaster #(
    .FU_NUM     (FU),
    .FIFO_DEPTH (DEPTH),
    .CDB_SIZE   (CDB),
    .ROB_BITS   (RB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_reorder (fu_reorder),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb        (cdb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < FU; i++) mq[i].delete();
    for (int l = 0; l < CDB; l++) exp_lane[l] = '0;
    rr = 0;
  endfunction

  function automatic logic [FU-1:0] model_ready();
    logic [FU-1:0] r;
    r = '0;
    for (int i = 0; i < FU; i++) r[i] = (mq[i].size() < DEPTH) && !flush;
    return r;
  endfunction

  // Model: grant from queue contents before this edge, then accept new results.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < FU; i++) m_acc[i] = fu_valid[i] && (mq[i].size() < DEPTH);
      for (int l = 0; l < CDB; l++) exp_lane[l] = '0;
      m_n    = 0;
      m_last = -1;
      for (int k = 0; k < FU; k++) begin
        m_p = (rr + k) % FU;
        if (mq[m_p].size() != 0 && m_n < CDB) begin
          m_head        = mq[m_p].pop_front();
          exp_lane[m_n] = {1'b1, m_head};
          m_n++;
          m_last = m_p;
        end
      end
      if (m_last >= 0) rr = (m_last + 1) % FU;
      for (int i = 0; i < FU; i++)
        if (m_acc[i]) mq[i].push_back({fu_reorder[i], fu_value[i]});
    end
  end

  always @(negedge rst_n) model_clear();

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < CDB; l++)
        checkOutput($sformatf("cdb lane %0d", l), 64'(cdb[l]), 64'(exp_lane[l]));
      checkOutput("fu_ready", 64'(fu_ready), 64'(model_ready()));
    end
  end

  task automatic applyStimulus(input logic [FU-1:0] v, input logic fl);
    fu_valid = v;
    flush    = fl;
  endtask

  task automatic set_port(input int i, input logic [RB-1:0] tag, input logic [31:0] val);
    fu_reorder[i] = tag;
    fu_value[i]   = val;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < FU; i++) set_port(i, RB'($urandom), $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cdb_zero(input string name);
    for (int l = 0; l < CDB; l++)
      checkOutput($sformatf("%s lane %0d", name, l), 64'(cdb[l]), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [FU-1:0] v;
    applyStimulus('0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    check_cdb_zero("reset cdb");
    checkOutput("reset fu_ready", 64'(fu_ready), 64'(4'hF));
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single result on port 1
    set_port(1, 5'd5, 32'hDEADBEEF);
    applyStimulus(4'b0010, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(); #2;
    checkOutput("single lane0", 64'(cdb[0]), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    checkOutput("single lane1 valid", 64'(cdb[1][LB-1]), 64'(0));
    tick(); #2;
    check_cdb_zero("single after");

    // All four ports at once from rr=0
    applyStimulus('0, 1'b1);
    tick();
    for (int i = 0; i < FU; i++) set_port(i, RB'(10 + i), 32'(100 + i));
    applyStimulus(4'hF, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(); #2;
    checkOutput("all4 first lane0", 64'(cdb[0]), 64'({1'b1, 5'd10, 32'd100}));
    checkOutput("all4 first lane1", 64'(cdb[1]), 64'({1'b1, 5'd11, 32'd101}));
    tick(); #2;
    checkOutput("all4 second lane0", 64'(cdb[0]), 64'({1'b1, 5'd12, 32'd102}));
    checkOutput("all4 second lane1", 64'(cdb[1]), 64'({1'b1, 5'd13, 32'd103}));
    // rr back at 0: port 0 must precede port 3
    set_port(0, 5'd20, 32'd200);
    set_port(3, 5'd23, 32'd203);
    applyStimulus(4'b1001, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(); #2;
    checkOutput("rr wrap lane0", 64'(cdb[0]), 64'({1'b1, 5'd20, 32'd200}));
    checkOutput("rr wrap lane1", 64'(cdb[1]), 64'({1'b1, 5'd23, 32'd203}));

    // Saturation: four producers against two lanes
    randomize_payload();
    applyStimulus(4'hF, 1'b0);
    tick();
    randomize_payload();
    tick(); #2;
    checkOutput("saturate ready A", 64'(fu_ready), 64'(4'b0011));
    tick(); #2;
    checkOutput("saturate ready B", 64'(fu_ready), 64'(4'b1100));

    // Flush with queued entries
    applyStimulus(4'hF, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    #2;
    check_cdb_zero("flush cdb");
    checkOutput("flush fu_ready", 64'(fu_ready), 64'(4'hF));
    tick(); #2;
    check_cdb_zero("flush stale1");
    tick(); #2;
    check_cdb_zero("flush stale2");

    // Async reset pulse between edges while port 2 still holds an entry
    for (int i = 0; i < FU; i++) set_port(i, RB'(24 + i), 32'hA000 + 32'(i));
    applyStimulus(4'b0111, 1'b0);
    tick();
    applyStimulus('0, 1'b0);
    tick(); #1;
    checkOutput("pre-reset lane0", 64'(cdb[0]), 64'({1'b1, 5'd24, 32'hA000}));
    rst_n = 1'b0;
    #1;
    check_cdb_zero("async reset cdb");
    checkOutput("async reset fu_ready", 64'(fu_ready), 64'(4'hF));
    rst_n = 1'b1;
    tick(); #2;
    check_cdb_zero("post reset1");
    tick(); #2;
    check_cdb_zero("post reset2");

    // Randomized traffic with occasional flush and reset pulses
    for (int c = 0; c < 3000; c++) begin
      randomize_payload();
      if (c[6]) v = 4'($urandom) | 4'($urandom);
      else      v = 4'($urandom) & 4'($urandom);
      applyStimulus(v, $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    applyStimulus('0, 1'b0);
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 Parameter FU_NUM, default 4, number of functional-unit result ports (2..8).
REQ-002 Parameter FIFO_DEPTH, default 2, per-port result queue depth (power of two, >=2).
REQ-003 Parameter CDB_SIZE, default `CDB_SIZE, number of CDB lanes (1..FU_NUM).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous pipeline flush (mispredict/exception).
REQ-007 fu_valid  in  FU_NUM  per-port result valid.
REQ-008 fu_reorder  in  FU_NUM x rob_index_t  ROB tag of result.
REQ-009 fu_value  in  FU_NUM x 32  result data.
REQ-010 fu_ready  out  FU_NUM  port can accept a result this cycle.
REQ-011 cdb  out  cdb_packet_t (CDB_SIZE lanes of valid/reorder/value)  registered broadcast consumed by register status table, reservation stations, ROB.

Function
REQ-012 Transfer on port i occurs when fu_valid[i] && fu_ready[i] at a rising edge; payload is pushed into FIFO i.
REQ-013 fu_ready[i] = (count[i] < FIFO_DEPTH) && !flush; no dependence on same-cycle pop (no full-queue bypass).
REQ-014 A pushed entry is eligible for arbitration from the cycle after the push; no same-cycle bypass.
REQ-015 Each cycle the arbiter scans ports rr_ptr, rr_ptr+1, ... mod FU_NUM and grants the first min(CDB_SIZE, nonempty count) nonempty FIFOs.
REQ-016 Granted heads are popped at the edge and registered onto cdb lanes in grant order, lane 0 first.
REQ-017 Unused lanes drive valid=0, reorder=0, value=0.
REQ-018 rr_ptr updates to (last granted port + 1) mod FU_NUM; unchanged if no grant.
REQ-019 Minimum latency: accept at edge k -> cdb lane valid after edge k+1, held exactly one cycle.
REQ-020 Simultaneous push and pop on one FIFO in the same cycle: count unchanged, order preserved (FIFO order per port strictly kept).
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-022 No port is starved: a nonempty FIFO is granted within ceil(FU_NUM/CDB_SIZE) cycles.
REQ-023 A given reorder tag appears on at most one lane per cycle (guaranteed by ROB uniqueness; not checked).
REQ-024 flush=1: all FIFOs emptied, rr_ptr <= 0, all cdb lanes valid <= 0 at that edge; inputs that cycle dropped; no grant issued.
REQ-025 flush has priority over push, pop and arbitration.

Reset
REQ-026 rst_n=0 asynchronously clears all FIFOs (count 0, pointers 0), rr_ptr=0, cdb all zero; fu_ready reads 1 while rst_n=0 is released and flush=0.
REQ-027 Reset asserted mid-transfer discards all queued and in-flight results; first post-reset grant starts at port 0.

Verification
REQ-028 FU_NUM=4, CDB_SIZE=2: single push port 1 {reorder=5, value=0xDEADBEEF} at edge 0 -> cdb[0]={1,5,0xDEADBEEF} after edge 1, cdb[1].valid=0, all zero after edge 2.
REQ-029 All 4 ports push once at edge 0, rr_ptr=0 -> after edge 1 lanes carry ports 0,1; after edge 2 ports 2,3; rr_ptr returns 0.
REQ-030 Port 0 pushes 3 back-to-back with no grants possible (other ports saturating priority, CDB_SIZE=1) -> fu_ready[0]=0 after 2 entries; third held until a pop, then accepted in order.
REQ-031 Push and grant same cycle on full FIFO 2 -> count stays 2, fu_ready[2] stays 0, output order matches push order.
REQ-032 flush with 3 ports holding entries -> next cycle cdb all invalid, fu_ready all 1, rr_ptr=0, no stale tag ever broadcast.
REQ-033 rst_n pulsed low asynchronously between edges while entries queued -> cdb zero immediately, no queued tag appears after release.
